// File: rtl/debouncer_bank_if.sv
// debouncer_bank_if: signal bundle between raw pads / control logic and the
// debouncer bank.
//   master modport : drives i_en and iv_input, observes the debounced outputs
//   slave  modport : the debouncer itself
// Signals:
//   i_en          debounce enable
//   iv_input      raw asynchronous inputs, one bit per channel
//   ov_output     debounced levels
//   ov_rise       one-cycle pulse per channel on a 0->1 change of ov_output
//   ov_fall       one-cycle pulse per channel on a 1->0 change of ov_output
//   o_any_change  OR of every rise/fall bit
interface debouncer_bank_if #(
  parameter int p_CHANNELS = 4
) ();
  logic                  i_en;
  logic [p_CHANNELS-1:0] iv_input;
  logic [p_CHANNELS-1:0] ov_output;
  logic [p_CHANNELS-1:0] ov_rise;
  logic [p_CHANNELS-1:0] ov_fall;
  logic                  o_any_change;

  modport master (
    output i_en,
    output iv_input,
    input  ov_output,
    input  ov_rise,
    input  ov_fall,
    input  o_any_change
  );

  modport slave (
    input  i_en,
    input  iv_input,
    output ov_output,
    output ov_rise,
    output ov_fall,
    output o_any_change
  );
endinterface

// File: rtl/debouncer_bank.sv
// debouncer_bank: multi-channel switch debouncer.
// Each channel synchronises its raw input, then qualifies a level change only
// after 2**p_CNT_WIDTH consecutive mismatch ticks of a shared prescaler. A
// qualified change updates the debounced level and emits a one-cycle rise or
// fall pulse.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   bus      debouncer_bank_if slave modport (enable, raw inputs, outputs)
module debouncer_bank #(
  parameter int   p_CHANNELS    = 4,
  parameter int   p_CNT_WIDTH   = 4,
  parameter int   p_PRESCALE    = 1,
  parameter int   p_SYNC_STAGES = 2,
  parameter logic p_RESET_LEVEL = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  debouncer_bank_if.slave        bus
);

  localparam int unsigned       PRE_W    = (p_PRESCALE > 1) ? $clog2(p_PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(p_PRESCALE - 1);

  logic [p_CHANNELS-1:0]  sync_q [p_SYNC_STAGES];
  logic [p_CHANNELS-1:0]  s;
  logic [PRE_W-1:0]       pre_q, pre_d;
  logic                   tick;
  logic [p_CNT_WIDTH-1:0] cnt_q [p_CHANNELS];
  logic [p_CNT_WIDTH-1:0] cnt_d [p_CHANNELS];
  logic [p_CHANNELS-1:0]  out_q, out_d;
  logic [p_CHANNELS-1:0]  rise_q, rise_d;
  logic [p_CHANNELS-1:0]  fall_q, fall_d;

  // Synchroniser runs regardless of enable so the sampled level is always fresh.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < p_SYNC_STAGES; i++) begin
        sync_q[i] <= {p_CHANNELS{p_RESET_LEVEL}};
      end
    end else begin
      sync_q[0] <= bus.iv_input;
      for (int unsigned i = 1; i < p_SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s    = sync_q[p_SYNC_STAGES-1];
  // With p_PRESCALE == 1 the prescaler stays at 0 == PRE_LAST, so tick is constant 1.
  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    pre_d = '0;
    if (bus.i_en && !tick) begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_comb begin
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    for (int unsigned ch = 0; ch < p_CHANNELS; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      if (!bus.i_en || (s[ch] == out_q[ch])) begin
        cnt_d[ch] = '0;
      end else if (tick) begin
        if (&cnt_q[ch]) begin
          out_d[ch]  = s[ch];
          cnt_d[ch]  = '0;
          rise_d[ch] = s[ch];
          fall_d[ch] = ~s[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_q  <= '0;
      out_q  <= {p_CHANNELS{p_RESET_LEVEL}};
      rise_q <= '0;
      fall_q <= '0;
      for (int unsigned ch = 0; ch < p_CHANNELS; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      pre_q  <= pre_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int unsigned ch = 0; ch < p_CHANNELS; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  assign bus.ov_output    = out_q;
  assign bus.ov_rise      = rise_q;
  assign bus.ov_fall      = fall_q;
  assign bus.o_any_change = |(rise_q | fall_q);

endmodule

// File: tb/tb_debouncer_bank.sv
// Testbench for debouncer_bank: dut_a uses p_PRESCALE=1, dut_b uses p_PRESCALE=3.
// Stimulus pushes expected pulse events into per-DUT queues; monitors pop and
// compare whenever a DUT raises o_any_change.
module tb_debouncer_bank;

  typedef struct {
    int unsigned lo;
    int unsigned hi;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic [3:0]  out;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a_n;
  logic        rst_b_n;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        qa[$];
  exp_t        qb[$];

  debouncer_bank_if #(.p_CHANNELS(4)) a_if ();
  debouncer_bank_if #(.p_CHANNELS(4)) b_if ();

  debouncer_bank #(
    .p_CHANNELS(4), .p_CNT_WIDTH(2), .p_PRESCALE(1), .p_SYNC_STAGES(2), .p_RESET_LEVEL(1'b0)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_a_n), .bus(a_if.slave)
  );

  debouncer_bank #(
    .p_CHANNELS(4), .p_CNT_WIDTH(2), .p_PRESCALE(3), .p_SYNC_STAGES(2), .p_RESET_LEVEL(1'b0)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_b_n), .bus(b_if.slave)
  );

  always #5 clk = ~clk;

  // Edge number of the most recent rising clock edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_edge(input string name, input int unsigned act,
                          input int unsigned lo, input int unsigned hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_if.o_any_change === 1'b1) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_pulse", {a_if.ov_rise, a_if.ov_fall}, 32'h0);
      end else begin
        e = qa.pop_front();
        chk_edge("a_pulse_edge", cyc, e.lo, e.hi);
        chk("a_rise", a_if.ov_rise, e.rise);
        chk("a_fall", a_if.ov_fall, e.fall);
        chk("a_output", a_if.ov_output, e.out);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_if.o_any_change === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_pulse", {b_if.ov_rise, b_if.ov_fall}, 32'h0);
      end else begin
        e = qb.pop_front();
        chk_edge("b_pulse_edge", cyc, e.lo, e.hi);
        chk("b_rise", b_if.ov_rise, e.rise);
        chk("b_fall", b_if.ov_fall, e.fall);
        chk("b_output", b_if.ov_output, e.out);
      end
    end
  end

  // Waits (bounded) until the chosen queue has been consumed by its monitor.
  task automatic drain(input bit use_b, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if ((use_b ? qb.size() : qa.size()) == 0) begin
        checks++;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout actual=%0d pending required=0 pending", use_b ? "b" : "a",
             use_b ? qb.size() : qa.size());
    qa.delete();
    qb.delete();
  endtask

  task automatic chk_a_reset(input string name);
    chk({name, "_out"},  a_if.ov_output, 32'h0);
    chk({name, "_rise"}, a_if.ov_rise, 32'h0);
    chk({name, "_fall"}, a_if.ov_fall, 32'h0);
    chk({name, "_any"},  a_if.o_any_change, 32'h0);
  endtask

  initial begin
    int unsigned e;
    logic [3:0] pat [4];
    pat[0] = 4'b1111; pat[1] = 4'b0101; pat[2] = 4'b1010; pat[3] = 4'b0011;

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    a_if.i_en = 1'b1;
    b_if.i_en = 1'b1;
    a_if.iv_input = '0;
    b_if.iv_input = '0;

    // 1: outputs stay at reset level while inputs toggle under reset.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_if.iv_input = pat[i];
      b_if.iv_input = pat[i];
      #1;
      chk_a_reset("reset_hold");
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a_if.iv_input = pat[i % 4];
      #1;
      chk_a_reset("reset_hold_late");
    end
    @(negedge clk);
    a_if.iv_input = '0;
    b_if.iv_input = '0;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk_a_reset("after_release");

    // 2: clean rising edge on ch0, sampled at edge e -> pulse at e+5.
    @(negedge clk);
    a_if.iv_input = 4'b0001;
    e = cyc + 1;
    qa.push_back('{lo: e + 5, hi: e + 5, rise: 4'b0001, fall: 4'b0000, out: 4'b0001});
    drain(1'b0, 20);
    @(negedge clk);
    #1;
    chk("clean_rise_cleared", a_if.ov_rise, 32'h0);
    chk("clean_output_held", a_if.ov_output, 32'h1);

    // 3: bounce on ch1: high 3, low 1, then high; only the final high qualifies.
    @(negedge clk);
    a_if.iv_input = 4'b0011;
    repeat (3) @(negedge clk);
    a_if.iv_input = 4'b0001;
    @(negedge clk);
    a_if.iv_input = 4'b0011;
    e = cyc + 1;
    qa.push_back('{lo: e + 5, hi: e + 5, rise: 4'b0010, fall: 4'b0000, out: 4'b0011});
    drain(1'b0, 20);

    // 4: pre-qualify ch3 high, then ch2 rises and ch3 falls together.
    @(negedge clk);
    a_if.iv_input = 4'b1011;
    e = cyc + 1;
    qa.push_back('{lo: e + 5, hi: e + 5, rise: 4'b1000, fall: 4'b0000, out: 4'b1011});
    drain(1'b0, 20);
    @(negedge clk);
    a_if.iv_input = 4'b0111;
    e = cyc + 1;
    qa.push_back('{lo: e + 5, hi: e + 5, rise: 4'b0100, fall: 4'b1000, out: 4'b0111});
    drain(1'b0, 20);

    // 5: prescale 3 on dut_b. Tick phase is not controlled, so the 4th tick
    // lands 11..13 edges after the sampling edge.
    @(negedge clk);
    b_if.iv_input = 4'b0001;
    e = cyc + 1;
    qb.push_back('{lo: e + 11, hi: e + 13, rise: 4'b0001, fall: 4'b0000, out: 4'b0001});
    drain(1'b1, 40);
    // Falling change: at most 2 ticks elapse before enable drops.
    @(negedge clk);
    b_if.iv_input = 4'b0000;
    repeat (7) @(negedge clk);
    b_if.i_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("disabled_output_hold", b_if.ov_output, 32'h1);
      chk("disabled_no_pulse", {b_if.ov_rise, b_if.ov_fall}, 32'h0);
    end
    // Prescaler restarts at 0: ticks at r+2, r+5, r+8, r+11.
    b_if.i_en = 1'b1;
    e = cyc + 1;
    qb.push_back('{lo: e + 11, hi: e + 11, rise: 4'b0000, fall: 4'b0001, out: 4'b0000});
    drain(1'b1, 40);

    // 6: reset dut_a while ch0 has counted 3 mismatch ticks.
    @(negedge clk);
    a_if.iv_input = 4'b0110;
    e = cyc + 1;
    qa.push_back('{lo: e + 5, hi: e + 5, rise: 4'b0000, fall: 4'b0001, out: 4'b0110});
    drain(1'b0, 20);
    @(negedge clk);
    a_if.iv_input = 4'b0111;
    repeat (5) @(negedge clk);
    rst_a_n = 1'b0;
    #1;
    chk_a_reset("midcount_reset");
    @(negedge clk);
    #1;
    chk_a_reset("midcount_reset_hold");
    rst_a_n = 1'b1;
    e = cyc + 1;
    qa.push_back('{lo: e + 5, hi: e + 5, rise: 4'b0111, fall: 4'b0000, out: 4'b0111});
    drain(1'b0, 20);

    repeat (3) @(negedge clk);
    #1;
    chk("final_queue_a", qa.size(), 32'h0);
    chk("final_queue_b", qb.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
